// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM, one-entry stall buffer, IF/ID register and field decode
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = branch_target & ~32'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    if (!imem_valid) state_d = DRAIN;
                end else if (stall && imem_valid) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (branch_taken || !stall) state_d = FETCH;
            end
            DRAIN: begin
                if (imem_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // No request while in reset or while the buffered word waits for the stall to clear.
    always_comb begin
        imem_req  = rst_n && (state_q != HOLD);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    pc_d       = target;
                    id_valid_d = 1'b0;
                    id_instr_d = 32'd0;
                    if (!imem_valid) drain_addr_d = pc_q;
                end else if (imem_valid) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                    end else begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem_rdata;
                        id_pc4_d   = pc_plus4;
                    end
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d        = target;
                    buf_instr_d = 32'd0;
                    buf_pc4_d   = 32'd0;
                    id_valid_d  = 1'b0;
                    id_instr_d  = 32'd0;
                end else if (!stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = buf_instr_q;
                    id_pc4_d   = buf_pc4_q;
                end
            end
            DRAIN: begin
                // The in-flight word belongs to the old path; only the redirect target moves.
                if (branch_taken) begin
                    pc_d       = target;
                    id_valid_d = 1'b0;
                    id_instr_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC & ~32'd3;
            drain_addr_q <= 32'd0;
            buf_instr_q  <= 32'd0;
            buf_pc4_q    <= 32'd0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'd0;
            id_pc4_q     <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc4_q;

    assign opcode   = id_instr_q[31:26];
    assign rs       = id_instr_q[25:21];
    assign rt       = id_instr_q[20:16];
    assign rd       = id_instr_q[15:11];
    assign funct    = id_instr_q[5:0];
    assign imm_sext = {{16{id_instr_q[15]}}, id_instr_q[15:0]};

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized scoreboard bench for if_stage against a queue-based fetch model
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
    } req_t;

    typedef struct packed {
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
    } id_t;

    req_t q_req[$];
    id_t  q_id[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: next fetch address, addresses whose data must be thrown away, words parked by a stall.
    logic [31:0] m_pc;
    logic [31:0] m_stale[$];
    logic [63:0] m_held[$];
    id_t         m_id;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C22_0004;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_stale.delete();
        m_held.delete();
        m_id = '0;
    endtask

    task automatic cycle(input logic s, input logic b, input logic [31:0] t, input logic v);
        req_t r;
        @(negedge clk);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_valid    = v;
        imem_rdata    = v ? mem(imem_addr) : $urandom();

        if (m_held.size() > 0)       r = '{req: 1'b0, addr: 32'd0};
        else if (m_stale.size() > 0) r = '{req: 1'b1, addr: m_stale[0]};
        else                         r = '{req: 1'b1, addr: m_pc};
        q_req.push_back(r);

        if (m_held.size() > 0) begin
            if (b) begin
                m_held.delete();
                m_pc = t & ~32'd3;
                m_id.v = 1'b0; m_id.i = 32'd0;
            end else if (!s) begin
                m_id.v = 1'b1;
                m_id.i = m_held[0][63:32];
                m_id.p = m_held[0][31:0];
                void'(m_held.pop_front());
            end
        end else if (m_stale.size() > 0) begin
            if (b) begin
                m_pc = t & ~32'd3;
                m_id.v = 1'b0; m_id.i = 32'd0;
            end
            if (v) void'(m_stale.pop_front());
        end else begin
            if (b) begin
                m_id.v = 1'b0; m_id.i = 32'd0;
                if (!v) m_stale.push_back(m_pc);
                m_pc = t & ~32'd3;
            end else if (v) begin
                if (s) m_held.push_back({mem(m_pc), m_pc + 32'd4});
                else   m_id = '{v: 1'b1, i: mem(m_pc), p: m_pc + 32'd4};
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_id.v = 1'b0;
            end
        end
        q_id.push_back(m_id);
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    endtask

    // Reset asserted between edges so its effect is observed asynchronously.
    task automatic do_reset();
        @(posedge clk);
        #3;
        stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : mon_req
        req_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_req.size() > 0) begin
                e = q_req.pop_front();
                chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
                if (e.req) chk("imem_addr", imem_addr, e.addr);
            end
        end
    end

    initial begin : mon_id
        id_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_id.size() > 0) begin
                e = q_id.pop_front();
                chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
                chk("id_instr", id_instr, e.i);
                chk("id_pc_plus4", id_pc_plus4, e.p);
                chk("opcode", {26'd0, opcode}, e.i >> 26);
                chk("rs", {27'd0, rs}, (e.i >> 21) & 32'h1F);
                chk("rt", {27'd0, rt}, (e.i >> 16) & 32'h1F);
                chk("rd", {27'd0, rd}, (e.i >> 11) & 32'h1F);
                chk("funct", {26'd0, funct}, e.i & 32'h3F);
                chk("imm_sext", imm_sext, ((e.i & 32'hFFFF) ^ 32'h8000) - 32'h8000);
            end
        end
    end

    initial begin : stim
        logic [31:0] t;
        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        imem_valid = 1'b0; imem_rdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #2;
        rst_n = 1'b1;

        cycle(0, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(1, 0, 32'd0, 1);
        cycle(1, 0, 32'd0, 1);
        cycle(1, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 0);
        cycle(0, 1, 32'h8, 1);
        cycle(0, 1, 32'h40, 0);
        cycle(0, 0, 32'd0, 0);
        cycle(0, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(1, 1, 32'h103, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(0, 1, 32'h200, 0);
        do_reset();
        cycle(0, 0, 32'd0, 1);

        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) do_reset();
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom();
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, t,
                  $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
